uart_tx_scheduler: RTL and testbench

//   Shares one uart_send transmitter between NUM_CH byte requesters using round-robin arbitration.

---
 rtl/uart_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one uart_send transmitter between NUM_CH byte requesters.
// Owns all frame timing: grant, one-cycle uart_en strobe, then a full frame plus guard gap of hold-off.

module uart_tx_scheduler_param_chk #(
    parameter int NUM_CH    = 4,
    parameter int FRAME_CNT = 4774
) ();
    // Elaboration-time range checks on the derived timing constants
    generate
        if (FRAME_CNT >= (1 << 20)) begin : g_frame_too_long
            $error("FRAME_CNT does not fit the 20-bit wait counter");
        end
        if ((NUM_CH < 2) || (NUM_CH > 8)) begin : g_bad_num_ch
            $error("NUM_CH must be in 2..8");
        end
    endgenerate
endmodule

module uart_tx_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int GAP_BITS  = 1,
    parameter int BPS_CNT   = CLK_FREQ / UART_BPS,
    parameter int FRAME_CNT = (10 + GAP_BITS) * BPS_CNT,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [NUM_CH*8-1:0]   req_data,
    output logic [NUM_CH-1:0]     req_ready,
    output logic                  uart_en,
    output logic [7:0]            uart_data,
    output logic                  busy,
    output logic                  tx_done,
    output logic [CH_W-1:0]       tx_ch
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [19:0] WAIT_LAST = 20'(FRAME_CNT - 1);
    localparam logic [19:0] WAIT_PRE  = 20'(FRAME_CNT - 2);

    uart_tx_scheduler_param_chk #(
        .NUM_CH    (NUM_CH),
        .FRAME_CNT (FRAME_CNT)
    ) u_param_chk ();

    state_t              state_r,     state_nxt_s;
    logic [CH_W-1:0]     rr_ptr_r,    rr_ptr_nxt_s;
    logic [19:0]         wait_cnt_r,  wait_cnt_nxt_s;
    logic [NUM_CH-1:0]   ready_r,     ready_nxt_s;
    logic                uart_en_r,   uart_en_nxt_s;
    logic [7:0]          data_r,      data_nxt_s;
    logic                busy_r,      busy_nxt_s;
    logic                tx_done_r,   tx_done_nxt_s;
    logic [CH_W-1:0]     tx_ch_r,     tx_ch_nxt_s;
    logic [CH_W-1:0]     winner_s;

    // First set request at or above ptr, wrapping; lowest offset from ptr wins
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] vld,
                                                 input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] pick;
        int              idx;
        pick = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (vld[idx]) begin
                pick = CH_W'(idx);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Next-state and next-output computation for the scheduler FSM
    always_comb begin
        state_nxt_s    = state_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        wait_cnt_nxt_s = wait_cnt_r;
        ready_nxt_s    = {NUM_CH{1'b0}};
        uart_en_nxt_s  = 1'b0;
        data_nxt_s     = data_r;
        tx_done_nxt_s  = 1'b0;
        tx_ch_nxt_s    = tx_ch_r;
        winner_s       = rr_pick(req_valid, rr_ptr_r);
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    tx_ch_nxt_s = winner_s;
                    ready_nxt_s = {{(NUM_CH-1){1'b0}}, 1'b1} << winner_s;
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Data is taken here whether or not valid is still asserted
                data_nxt_s    = req_data[8*tx_ch_r +: 8];
                rr_ptr_nxt_s  = CH_W'((int'(tx_ch_r) + 1) % NUM_CH);
                uart_en_nxt_s = 1'b1;
                state_nxt_s   = ST_SEND;
            end
            ST_SEND: begin
                wait_cnt_nxt_s = 20'd0;
                state_nxt_s    = ST_WAIT;
            end
            ST_WAIT: begin
                // tx_done is registered, so it is armed one count early to land on the last WAIT cycle
                tx_done_nxt_s = (wait_cnt_r == WAIT_PRE);
                if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 20'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {CH_W{1'b0}};
            wait_cnt_r <= 20'd0;
            ready_r    <= {NUM_CH{1'b0}};
            uart_en_r  <= 1'b0;
            data_r     <= 8'h00;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
            tx_ch_r    <= {CH_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            ready_r    <= ready_nxt_s;
            uart_en_r  <= uart_en_nxt_s;
            data_r     <= data_nxt_s;
            busy_r     <= busy_nxt_s;
            tx_done_r  <= tx_done_nxt_s;
            tx_ch_r    <= tx_ch_nxt_s;
        end
    end

    assign req_ready = ready_r;
    assign uart_en   = uart_en_r;
    assign uart_data = data_r;
    assign busy      = busy_r;
    assign tx_done   = tx_done_r;
    assign tx_ch     = tx_ch_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler against a timeline model of grant/strobe/hold-off behaviour.
// Scaled baud parameters keep each frame short (FRAME_CNT = 110 clocks).

module tb_uart_tx_scheduler;

    localparam int NUM_CH   = 4;
    localparam int CLK_FREQ = 1000;
    localparam int UART_BPS = 100;
    localparam int GAP_BITS = 1;
    localparam int CH_W     = 2;
    localparam int FRAME    = (10 + GAP_BITS) * (CLK_FREQ / UART_BPS);
    localparam int PER      = FRAME + 3;
    localparam int END_A    = 150;
    localparam int END_B    = END_A + 7 * PER;
    localparam int END_C    = END_B + 5 * PER;
    localparam int N_CYC    = 5000;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n;
    logic [NUM_CH-1:0]     req_valid;
    logic [NUM_CH*8-1:0]   req_data;
    logic [NUM_CH-1:0]     req_ready;
    logic                  uart_en;
    logic [7:0]            uart_data;
    logic                  busy;
    logic                  tx_done;
    logic [CH_W-1:0]       tx_ch;

    uart_tx_scheduler #(
        .NUM_CH   (NUM_CH),
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .uart_en   (uart_en),
        .uart_data (uart_data),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_ch     (tx_ch)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: DUT is free or committed to one frame that started at cycle m_t0
    bit        m_busy;
    int        m_t0, m_win, m_ptr, m_ch;
    logic [7:0] m_byte;

    // Requester side
    bit        pend [NUM_CH];
    logic [7:0] pbyte [NUM_CH];

    function automatic int rr_ref(input logic [NUM_CH-1:0] vld, input int ptr);
        for (int k = 0; k < NUM_CH; k++) begin
            if (vld[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_t0   = 0;
        m_win  = 0;
        m_ptr  = 0;
        m_ch   = 0;
        m_byte = 8'h00;
    endtask

    task automatic check_outputs(input string pfx);
        int          d;
        logic [3:0]  e_ready;
        d       = cyc - m_t0;
        e_ready = 4'b0000;
        if (m_busy && d == 1) e_ready[m_win] = 1'b1;
        check_val({pfx, "ready"},   32'(req_ready), 32'(e_ready));
        check_val({pfx, "uart_en"}, 32'(uart_en),   32'(m_busy && d == 2));
        check_val({pfx, "busy"},    32'(busy),      32'(m_busy));
        check_val({pfx, "tx_done"}, 32'(tx_done),   32'(m_busy && d == FRAME + 2));
        check_val({pfx, "data"},    32'(uart_data), 32'(m_byte));
        check_val({pfx, "tx_ch"},   32'(tx_ch),     32'(m_ch));
    endtask

    initial begin
        int  rst_left;
        bit  rst_done;
        bit  granted [NUM_CH];
        int  w, d, last_en, n_en;
        model_reset();
        rst_left  = 0;
        rst_done  = 1'b0;
        last_en   = -1;
        n_en      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend[i]  = 1'b0;
            pbyte[i] = 8'h00;
        end
        sys_rst_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge sys_clk);
        check_outputs("rst_");
        sys_rst_n = 1'b1;
        // Directed opening: channel 0 alone with A5
        pend[0]  = 1'b1;
        pbyte[0] = 8'hA5;

        for (cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc > 0) @(negedge sys_clk);
            check_outputs(rst_left > 0 ? "inrst_" : "");
            d = cyc - m_t0;

            // Back-to-back strobes under continuous requests must be exactly one period apart
            if (uart_en === 1'b1) begin
                if (last_en >= 0 && cyc >= END_A + PER && cyc < END_C && rst_left == 0)
                    check_val("en_spacing", 32'(cyc - last_en), 32'(PER));
                last_en = cyc;
                n_en++;
            end

            // Requesters drop valid once they see ready, holding data through the grant
            for (int i = 0; i < NUM_CH; i++) begin
                granted[i] = pend[i] && req_ready[i];
                if (granted[i]) pend[i] = 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!pend[i] && !granted[i] && cyc >= END_A) begin
                    if (cyc < END_B) begin
                        pend[i] = 1'b1;
                    end else if (cyc < END_C) begin
                        pend[i] = (i == 2);
                    end else begin
                        pend[i] = ($urandom_range(0, 39) == 0);
                    end
                    if (pend[i]) pbyte[i] = 8'($urandom_range(0, 255));
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                req_valid[i]         = pend[i];
                req_data[8*i +: 8]   = pbyte[i];
            end

            // One mid-WAIT reset, held for three cycles
            if (!rst_done && cyc > END_C && m_busy && d == 40) begin
                sys_rst_n = 1'b0;
                rst_left  = 3;
                rst_done  = 1'b1;
                model_reset();
                continue;
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left > 0) continue;
                sys_rst_n = 1'b1;
            end

            if (m_busy) begin
                if (d == 1) m_byte = req_data[8*m_win +: 8];
                if (d == FRAME + 2) m_busy = 1'b0;
            end else begin
                w = rr_ref(req_valid, m_ptr);
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_t0   = cyc;
                    m_win  = w;
                    m_ch   = w;
                    m_ptr  = (w + 1) % NUM_CH;
                end
            end
        end

        check_val("reset_injected", 32'(rst_done), 32'd1);
        check_val("frames_seen", 32'(n_en > 20), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
